div_array_sched: RTL and testbench
==================================

Name: div_array_sched

Overview:
- Sequencing controller that shares one 16/8 combinational array divider between NUM_REQ requesters.
- The divider pair is exact plus approximate variant, selected by a mux.
- Arbitrates round-robin and registers operands onto the divider inputs. Waits a programmable settle time for the array's borrow ripple, then captures q/r.
- Flags divide-by-zero and quotient overflow, and returns the result over a valid/ready response channel tagged with the requester id.
- Sits between accelerator lanes and the divider datapath. The divider itself stays outside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SETTLE_CYCLES, 3, cycles the divider inputs are held stable before q/r capture (1..15).
- ID_W, 2, width of the requester id; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_n  in  16*NUM_REQ  dividend per requester, packed.
- req_d  in  8*NUM_REQ  divisor per requester, packed.
- req_approx  in  NUM_REQ  1 = route to the approximate divider.
- div_n  out  16  registered dividend to the divider.
- div_d  out  8  registered divisor to the divider.
- div_approx  out  1  registered divider select.
- div_q  in  8  divider quotient (combinational from div_*).
- div_r  in  8  divider remainder.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  requester served.
- rsp_q  out  8  quotient.
- rsp_r  out  8  remainder.
- rsp_dz  out  1  divide-by-zero.
- rsp_ovf  out  1  quotient overflow.
- busy  out  1  FSM not in IDLE.

Behaviour:
- One clock. Reset is synchronous and active-high on rst. All registered outputs clear to 0 on reset, the FSM goes to IDLE, and the round-robin pointer goes to 0.
- FSM states are IDLE, SETTLE, RESP.
- IDLE:
  - req_ready is asserted combinationally for exactly one requester: the first requester with req_valid set, searching upward from the round-robin pointer (wrapping).
  - A handshake occurs when req_valid & req_ready. On that clock edge the block latches div_n, div_d, div_approx and the id, sets the pointer to id+1 modulo NUM_REQ, and moves to the next state.
  - If d==0 or n[15:8]>=d, the request takes the bypass: it skips the divider and goes straight to RESP.
  - Otherwise the settle counter loads SETTLE_CYCLES-1 and the FSM goes to SETTLE.
- SETTLE:
  - Counter decrements each cycle. At zero the block captures div_q/div_r into rsp_q/rsp_r and goes to RESP.
  - Request-to-rsp_valid latency is therefore SETTLE_CYCLES+1 cycles.
- RESP:
  - rsp_valid is held at 1 with all rsp_* fields stable until rsp_ready; that cycle returns the FSM to IDLE.
  - No new grant is issued in that cycle, so back-to-back issue is one grant every SETTLE_CYCLES+2 cycles at best.
- Divide-by-zero (bypass): rsp_dz=1, rsp_q=8'hFF, rsp_r=n[7:0], rsp_ovf=0. Latency is 1 cycle.
- Overflow (d!=0 and n[15:8]>=d, bypass): rsp_ovf=1, rsp_q=8'hFF, rsp_r=8'hFF, rsp_dz=0. Latency is 1 cycle.
- Flag rules: the overflow test is an exact 8-bit compare done in the controller and is independent of approx. rsp_dz and rsp_ovf are never both 1.
- Approximate results are passed through unchecked. The controller does not correct them.
- div_* outputs stay stable from grant until leaving SETTLE; they are not changed in RESP or IDLE without a grant.
- Requester rules: a requester deasserting req_valid without a grant is legal, and the pointer does not advance. req_* must stay stable while req_valid=1 and no grant has occurred.
- Reset mid-operation: any state returns to IDLE the next cycle, rsp_valid=0, and the in-flight result is dropped with no response.
- rsp_ready arriving when rsp_valid=0 is ignored.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SETTLE, RESP};
  - constants DZ_Q=8'hFF, OVF_Q=8'hFF, OVF_R=8'hFF;
  - a response struct {id, q, r, dz, ovf}.
- One sub-module: div_rr_arbiter. It takes a NUM_REQ-wide request vector and the pointer, and returns a one-hot grant plus the encoded id.
- The divider datapath is instantiated by the parent, not inside this block.

Test Plan:
- Exact single request: req0 n=16'd1000, d=8'd7, approx=0, SETTLE_CYCLES=3 -> rsp_valid at cycle 4 after grant, rsp_q=142, rsp_r=6, dz=0, ovf=0, id=0.
- Divide-by-zero: n=16'h1234, d=0 -> rsp_valid 1 cycle after grant, q=8'hFF, r=8'h34, dz=1; div_n/div_d hold the latched operands, but div_q/div_r are never captured.
- Overflow: n=16'h0800, d=8 -> ovf=1, q=8'hFF, r=8'hFF, 1-cycle latency; n=16'h07FF, d=8 -> normal path, q=255, r=7.
- Round-robin: req0..req3 all held valid -> grants in order 0,1,2,3,0. With only req2 and req0 valid and pointer=1 -> grant 2, then 0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready all 0, busy=1; releasing rsp_ready -> IDLE next cycle.
- Reset mid-SETTLE: assert rst for 1 cycle -> next cycle state IDLE, rsp_valid=0, pointer=0, and no response is ever issued for that request.

Source files
------------

// File: rtl/div_array_sched_pkg.sv
// div_array_sched_pkg: shared state, bypass constants and response record for the divider scheduler
package div_array_sched_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
    localparam logic [7:0] DZ_Q  = 8'hFF;
    localparam logic [7:0] OVF_Q = 8'hFF;
    localparam logic [7:0] OVF_R = 8'hFF;
    localparam int MAX_ID_W = 3;
    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [7:0]          q;
        logic [7:0]          r;
        logic                dz;
        logic                ovf;
    } rsp_t;
endpackage

// File: rtl/div_rr_arbiter.sv
// div_rr_arbiter: round-robin grant, first set request at or above i_ptr with wrap
// Ports: i_req request vector, i_ptr search start, o_gnt one-hot/zero grant, o_id encoded winner.
module div_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_id
);
    logic            w_found;
    logic [ID_W-1:0] w_k;
    always_comb begin
        o_gnt   = '0;
        o_id    = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = ID_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_k]) begin
                w_found    = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_id       = w_k;
            end
        end
    end
endmodule

// File: rtl/div_array_sched.sv
// div_array_sched: shares one external 16/8 array divider between NUM_REQ requesters
// Ports: req_* request channel per requester (valid/ready, packed operands, approx select);
//        div_* registered operands to / combinational results from the external divider;
//        rsp_* valid/ready result channel with id, q, r, divide-by-zero and overflow flags;
//        busy high whenever the sequencer is not idle.
module div_array_sched
    import div_array_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int ID_W          = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [16*NUM_REQ-1:0] req_n,
    input  logic [8*NUM_REQ-1:0]  req_d,
    input  logic [NUM_REQ-1:0]    req_approx,
    output logic [15:0]           div_n,
    output logic [7:0]            div_d,
    output logic                  div_approx,
    input  logic [7:0]            div_q,
    input  logic [7:0]            div_r,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [7:0]            rsp_q,
    output logic [7:0]            rsp_r,
    output logic                  rsp_dz,
    output logic                  rsp_ovf,
    output logic                  busy
);
    state_t             r_state, w_next;
    logic [3:0]         r_cnt;
    logic               r_served;
    rsp_t               r_rsp;
    logic [15:0]        r_div_n;
    logic [7:0]         r_div_d;
    logic               r_div_approx;
    logic [ID_W-1:0]    w_ptr, w_id;
    logic [NUM_REQ-1:0] w_gnt;
    logic [15:0]        w_n;
    logic [7:0]         w_d;
    logic               w_ap, w_hs, w_dz, w_ovf;

    // The round-robin pointer is implied by the last served id: one past it, or 0 after reset.
    assign w_ptr = (r_served && r_rsp.id < MAX_ID_W'(NUM_REQ-1)) ? r_rsp.id[ID_W-1:0] + 1'b1 : '0;

    div_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .i_req (req_valid),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt),
        .o_id  (w_id)
    );

    assign w_n   = 16'(req_n >> (16*w_id));
    assign w_d   = 8'(req_d >> (8*w_id));
    assign w_ap  = req_approx[w_id];
    assign w_hs  = (r_state == IDLE) && |req_valid;
    assign w_dz  = w_d == 8'd0;
    // Quotient cannot fit 8 bits when the high dividend byte already reaches the divisor.
    assign w_ovf = !w_dz && (w_n[15:8] >= w_d);

    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next = (r_state == IDLE)   ? (w_hs ? ((w_dz || w_ovf) ? RESP : SETTLE) : IDLE) :
                 (r_state == SETTLE) ? ((r_cnt == 4'd0) ? RESP : SETTLE) :
                                       (rsp_ready ? IDLE : RESP);
    end

    always_comb begin
        req_ready = (r_state == IDLE) ? w_gnt : '0;
        rsp_valid = r_state == RESP;
        busy      = r_state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_served     <= 1'b0;
            r_rsp        <= '0;
            r_div_n      <= '0;
            r_div_d      <= '0;
            r_div_approx <= 1'b0;
        end else if (w_hs) begin
            r_served     <= 1'b1;
            r_div_n      <= w_n;
            r_div_d      <= w_d;
            r_div_approx <= w_ap;
            r_cnt        <= 4'(SETTLE_CYCLES-1);
            r_rsp.id     <= MAX_ID_W'(w_id);
            r_rsp.dz     <= w_dz;
            r_rsp.ovf    <= w_ovf;
            r_rsp.q      <= w_dz ? DZ_Q : OVF_Q;
            r_rsp.r      <= w_dz ? w_n[7:0] : OVF_R;
        end else if (r_state == SETTLE) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd0) begin
                r_rsp.q <= div_q;
                r_rsp.r <= div_r;
            end
        end
    end

    assign div_n      = r_div_n;
    assign div_d      = r_div_d;
    assign div_approx = r_div_approx;
    assign rsp_id     = r_rsp.id[ID_W-1:0];
    assign rsp_q      = r_rsp.q;
    assign rsp_r      = r_rsp.r;
    assign rsp_dz     = r_rsp.dz;
    assign rsp_ovf    = r_rsp.ovf;
endmodule

// File: tb/tb_div_array_sched.sv
// tb_div_array_sched: directed checks of the divider scheduler against an external divider model
module tb_div_array_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready, req_approx;
    logic [63:0] req_n;
    logic [31:0] req_d;
    logic [15:0] div_n;
    logic [7:0]  div_d, div_q, div_r, rsp_q, rsp_r;
    logic        div_approx, rsp_valid, rsp_ready, rsp_dz, rsp_ovf, busy;
    logic [1:0]  rsp_id;
    int          checks = 0;
    int          failures = 0;

    div_array_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_n(req_n), .req_d(req_d), .req_approx(req_approx),
        .div_n(div_n), .div_d(div_d), .div_approx(div_approx),
        .div_q(div_q), .div_r(div_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External array divider: exact, or "approximate" with the quotient LSB flipped.
    always_comb begin
        div_q = 8'h00;
        div_r = 8'h00;
        if (div_d != 8'd0) begin
            div_q = 8'(div_n / 16'(div_d)) ^ {7'b0, div_approx};
            div_r = 8'(div_n % 16'(div_d));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int idx, input logic [15:0] n, input logic [7:0] d, input logic ap);
        req_n[idx*16 +: 16] = n;
        req_d[idx*8 +: 8]   = d;
        req_approx[idx]     = ap;
    endtask

    task automatic run(input string tag, input logic [3:0] vmask, input logic [1:0] eid,
                       input int elat, input logic [7:0] eq, input logic [7:0] er,
                       input logic edz, input logic eovf, input int hold);
        int lat;
        req_valid = vmask;
        #1;
        chk({tag, "_gnt"}, 32'(req_ready), 32'(4'b0001 << eid));
        tick;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick;
            lat++;
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_id"}, 32'(rsp_id), 32'(eid));
        chk({tag, "_q"}, 32'(rsp_q), 32'(eq));
        chk({tag, "_r"}, 32'(rsp_r), 32'(er));
        chk({tag, "_dz"}, 32'(rsp_dz), 32'(edz));
        chk({tag, "_ovf"}, 32'(rsp_ovf), 32'(eovf));
        for (int c = 0; c < hold; c++) begin
            tick;
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 1);
            chk({tag, "_hold_q"}, 32'(rsp_q), 32'(eq));
            chk({tag, "_hold_r"}, 32'(rsp_r), 32'(er));
            chk({tag, "_hold_ready"}, 32'(req_ready), 0);
            chk({tag, "_hold_busy"}, 32'(busy), 1);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        chk({tag, "_idle_valid"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        logic       seen;
        logic [7:0] rr_q [5];
        logic [7:0] rr_r [5];
        rr_q = '{8'd33, 8'd66, 8'd100, 8'd133, 8'd33};
        rr_r = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd1};
        rst = 1'b1;
        req_valid = '0;
        req_approx = '0;
        req_n = '0;
        req_d = '0;
        rsp_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_div_n", 32'(div_n), 0);
        chk("rst_rsp_q", 32'(rsp_q), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);

        set_op(0, 16'd1000, 8'd7, 1'b0);
        run("exact", 4'b0001, 2'd0, 4, 8'd142, 8'd6, 1'b0, 1'b0, 0);

        set_op(1, 16'h1234, 8'd0, 1'b0);
        run("dz", 4'b0010, 2'd1, 1, 8'hFF, 8'h34, 1'b1, 1'b0, 0);
        chk("dz_div_n", 32'(div_n), 32'h1234);
        chk("dz_div_d", 32'(div_d), 0);

        set_op(2, 16'h0800, 8'd8, 1'b0);
        run("ovf", 4'b0100, 2'd2, 1, 8'hFF, 8'hFF, 1'b0, 1'b1, 0);

        set_op(3, 16'h07FF, 8'd8, 1'b0);
        run("noovf_bp", 4'b1000, 2'd3, 4, 8'd255, 8'd7, 1'b0, 1'b0, 5);

        set_op(0, 16'd1000, 8'd7, 1'b1);
        run("approx", 4'b0001, 2'd0, 4, 8'd143, 8'd6, 1'b0, 1'b0, 0);
        chk("approx_sel", 32'(div_approx), 1);

        set_op(2, 16'd1000, 8'd7, 1'b0);
        req_valid = 4'b0100;
        #1;
        chk("rstmid_gnt", 32'(req_ready), 32'h4);
        tick;
        chk("rstmid_busy", 32'(busy), 1);
        tick;
        rst = 1'b1;
        req_valid = '0;
        tick;
        rst = 1'b0;
        chk("rstmid_idle", 32'(busy), 0);
        chk("rstmid_valid", 32'(rsp_valid), 0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            seen = seen | rsp_valid;
        end
        chk("rstmid_norsp", 32'(seen), 0);

        for (int i = 0; i < 4; i++) set_op(i, 16'(100*(i+1)), 8'd3, 1'b0);
        for (int k = 0; k < 5; k++)
            run("rr", 4'b1111, 2'(k % 4), 4, rr_q[k], rr_r[k], 1'b0, 1'b0, 0);

        run("rr2a", 4'b0101, 2'd2, 4, 8'd100, 8'd0, 1'b0, 1'b0, 0);
        run("rr2b", 4'b0101, 2'd0, 4, 8'd33, 8'd1, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
